// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types and the data-memory FSM encoding
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_be;

   typedef enum logic [3:0] {
      op_br   = 4'd0,
      op_add  = 4'd1,
      op_ldb  = 4'd2,
      op_stb  = 4'd3,
      op_jsr  = 4'd4,
      op_and  = 4'd5,
      op_ldr  = 4'd6,
      op_str  = 4'd7,
      op_rti  = 4'd8,
      op_not  = 4'd9,
      op_ldi  = 4'd10,
      op_sti  = 4'd11,
      op_jmp  = 4'd12,
      op_shf  = 4'd13,
      op_lea  = 4'd14,
      op_trap = 4'd15
   } lc3b_opcode;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      INDIRECT = 2'd2,
      DONE     = 2'd3
   } lc3b_dmem_state;

   function automatic logic is_mem_op(input lc3b_opcode op);
      case (op)
         op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// rtl/dmem_access_unit_if.sv - request/response bus between the MEM stage and the data cache
interface dmem_access_unit_if;
   import lc3b_types::*;

   logic       dmem_read;
   logic       dmem_write;
   lc3b_word   dmem_address;
   lc3b_word   dmem_wdata;
   lc3b_mem_be dmem_byte_enable;
   logic       dmem_resp;
   lc3b_word   dmem_rdata;

   modport master (
      output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
      input  dmem_resp, dmem_rdata
   );

   modport slave (
      input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
      output dmem_resp, dmem_rdata
   );

endinterface

// File: rtl/dmem_byte_align.sv
// rtl/dmem_byte_align.sv - LDB byte extraction, STB data replication and byte enables from addr[0]
module dmem_byte_align
   import lc3b_types::*;
(
   input  logic       addr_lsb,
   input  lc3b_word   rdata,
   input  lc3b_word   store_data,
   output lc3b_word   ldb_data,
   output lc3b_word   stb_wdata,
   output lc3b_mem_be byte_be
);

   assign ldb_data  = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
   assign stb_wdata = {store_data[7:0], store_data[7:0]};
   assign byte_be   = addr_lsb ? 2'b10 : 2'b01;

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MEM-stage data-memory access FSM with word, byte and indirect transfers
module dmem_access_unit
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_valid,
   input  lc3b_opcode opcode,
   input  lc3b_word   mem_addr,
   input  lc3b_word   store_data,
   output logic       stall_req,
   output logic       done,
   output lc3b_word   load_data,
   dmem_access_unit_if.master dmem
);

   localparam logic [1:0] S_IDLE     = IDLE;
   localparam logic [1:0] S_ACCESS   = ACCESS;
   localparam logic [1:0] S_INDIRECT = INDIRECT;
   localparam logic [1:0] S_DONE     = DONE;

   logic [1:0]  state;
   lc3b_opcode  op_q;
   lc3b_word    addr_q;
   lc3b_word    sd_q;
   logic [15:1] ptr_q;

   logic       accept;
   logic       q_byte, q_indirect, q_load, q_write_first;
   lc3b_word   ldb_data, stb_wdata;
   lc3b_mem_be byte_be;

   assign accept        = (state == S_IDLE) && mem_valid && is_mem_op(opcode);
   assign q_byte        = (op_q == op_ldb) || (op_q == op_stb);
   assign q_indirect    = (op_q == op_ldi) || (op_q == op_sti);
   assign q_load        = (op_q == op_ldr) || (op_q == op_ldb) || (op_q == op_ldi);
   assign q_write_first = (op_q == op_str) || (op_q == op_stb);

   assign stall_req = accept || (state == S_ACCESS) || (state == S_INDIRECT);

   dmem_byte_align u_align (
      .addr_lsb   (addr_q[0]),
      .rdata      (dmem.dmem_rdata),
      .store_data (sd_q),
      .ldb_data   (ldb_data),
      .stb_wdata  (stb_wdata),
      .byte_be    (byte_be)
   );

   // STI reads its pointer first, so only STR/STB write in ACCESS.
   always_comb begin
      dmem.dmem_read        = 1'b0;
      dmem.dmem_write       = 1'b0;
      dmem.dmem_address     = 16'h0000;
      dmem.dmem_wdata       = 16'h0000;
      dmem.dmem_byte_enable = 2'b00;
      case (state)
         S_ACCESS: begin
            dmem.dmem_read        = !q_write_first;
            dmem.dmem_write       = q_write_first;
            dmem.dmem_address     = {addr_q[15:1], 1'b0};
            dmem.dmem_byte_enable = q_byte ? byte_be : 2'b11;
            if (op_q == op_stb)
               dmem.dmem_wdata = stb_wdata;
            else if (op_q == op_str)
               dmem.dmem_wdata = sd_q;
         end
         S_INDIRECT: begin
            dmem.dmem_address     = {ptr_q, 1'b0};
            dmem.dmem_byte_enable = 2'b11;
            if (op_q == op_sti) begin
               dmem.dmem_write = 1'b1;
               dmem.dmem_wdata = sd_q;
            end else begin
               dmem.dmem_read = 1'b1;
            end
         end
         S_IDLE, S_DONE: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= op_br;
         addr_q    <= 16'h0000;
         sd_q      <= 16'h0000;
         ptr_q     <= 15'h0000;
         load_data <= 16'h0000;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= opcode;
                  addr_q <= mem_addr;
                  sd_q   <= store_data;
                  state  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (dmem.dmem_resp) begin
                  if (q_indirect) begin
                     ptr_q <= dmem.dmem_rdata[15:1];
                     state <= S_INDIRECT;
                  end else begin
                     if (q_load)
                        load_data <= q_byte ? ldb_data : dmem.dmem_rdata;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_INDIRECT: begin
               if (dmem.dmem_resp) begin
                  if (op_q == op_ldi)
                     load_data <= dmem.dmem_rdata;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
         endcase
      end
   end

endmodule
